fft_out_reorder: RTL and testbench
==================================

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 Parameter N, default 16, FFT frame length in complex points (power of two, 4..64).
REQ-002 Parameter BITREV, default 1; 1 selects bit-reversed read-out, 0 selects arrival-order read-out.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 fft_a  input  32  PE output sample, {real[31:16], imag[15:0]}, two's complement.
REQ-006 fft_b  input  32  PE output sample paired with fft_a, same format.
REQ-007 fft_pe_valid  input  1  fft_a/fft_b pair is valid this cycle; no backpressure toward the PE.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  32  reordered sample, {real, imag}.
REQ-010 out_valid  output  1  out_data/out_index valid.
REQ-011 out_index  output  log2(N)  natural-order bin number of out_data.
REQ-012 in_ready  output  1  high in COLLECT state; informs upstream that pairs will be stored.
REQ-013 frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted.
REQ-014 overflow  output  1  sticky error: a pair arrived while not in COLLECT.

Function
REQ-015 Storage: N x 32 memory; arrival index k = 2*p for fft_a, 2*p+1 for fft_b, p = pair counter 0..N/2-1.
REQ-016 States: COLLECT and DRAIN only.
REQ-017 COLLECT: on fft_pe_valid, write fft_a to mem[2p] and fft_b to mem[2p+1], then p increments.
REQ-018 COLLECT -> DRAIN on the cycle the pair with p = N/2-1 is written; p wraps to 0.
REQ-019 DRAIN: read counter r starts at 0; out_index = r; out_data = mem[bitrev(r)] if BITREV=1, else mem[r].
REQ-020 out_valid rises the first cycle after the COLLECT -> DRAIN transition; latency from last pair to first output = 1 cycle.
REQ-021 out_data, out_index and out_valid are held stable while out_valid=1 and out_ready=0.
REQ-022 On out_valid & out_ready, r increments, and the next sample is presented the next cycle with no bubble.
REQ-023 Acceptance with r = N-1: next cycle out_valid=0, frame_done=1 for exactly one cycle, state = COLLECT, r = 0.
REQ-024 fft_pe_valid in DRAIN, including the same cycle as the final acceptance: the pair is discarded, overflow sets, and memory and counters are unchanged.
REQ-025 overflow stays set until reset; it does not stop operation.
REQ-026 No arithmetic on data: the block passes samples bit-exact, with no scaling or rounding.
REQ-027 in_ready = 1 exactly when state = COLLECT.

Reset
REQ-028 While rst=0: state=COLLECT, p=0, r=0, out_valid=0, out_data=0, out_index=0, frame_done=0, overflow=0, in_ready=1.
REQ-029 Memory contents are not reset; no output exposes memory before a complete frame is written.
REQ-030 Reset asserted mid-frame (COLLECT or DRAIN) abandons the frame immediately; the first pair after release is treated as p=0.
REQ-031 Release of rst is synchronous-safe: the first active edge after release may capture a pair.

Verification
REQ-032 N=16, BITREV=1, 8 consecutive pairs p with fft_a={2p,16'h0}, fft_b={2p+1,16'h0}, out_ready=1 -> out_valid one cycle after pair 7; outputs index 0..15 carry real 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; frame_done one cycle after index 15.
REQ-033 Same stimulus with BITREV=0 -> outputs carry real 0..15 in order; imag = 0 throughout.
REQ-034 Pairs with gaps (fft_pe_valid on alternate cycles); out_ready toggling 1,0,0,1 -> out_data held while stalled; same 16-value sequence, no duplicates or drops.
REQ-035 An extra pair {16'h7FFF,16'h8000} is injected during DRAIN and on the final-acceptance cycle -> overflow=1 and sticky; output sequence unchanged; the next frame is collected correctly.
REQ-036 rst pulsed low after 3 pairs, and again at DRAIN index 5 -> all outputs return to reset values; a following full frame reorders correctly.
REQ-037 Values 16'h8000 and 16'hFFFF are placed in real and imag of several samples -> they appear at their reordered bins bit-exact.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// FFT output reorder bus: PE-side pair input plus reordered valid/ready output.
// Latency: n/a (signal bundle only).
// Backpressure: out_ready stalls the output side; the PE side has none (in_ready is advisory).
// Ports: fft_a/fft_b/fft_pe_valid from the PE, out_* toward downstream, status in_ready/frame_done/overflow.
interface fft_out_reorder_if #(
    parameter int N = 16
);
    localparam int LW = $clog2(N);

    logic [31:0]   fft_a;
    logic [31:0]   fft_b;
    logic          fft_pe_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic [LW-1:0] out_index;
    logic          in_ready;
    logic          frame_done;
    logic          overflow;

    // master drives the PE pairs and consumes the reordered stream
    modport master (
        output fft_a, fft_b, fft_pe_valid, out_ready,
        input  out_data, out_valid, out_index, in_ready, frame_done, overflow
    );

    // slave is the reorder block itself
    modport slave (
        input  fft_a, fft_b, fft_pe_valid, out_ready,
        output out_data, out_valid, out_index, in_ready, frame_done, overflow
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Collects one FFT frame of PE sample pairs, then streams it out in natural bin order.
// Latency: first output valid 1 cycle after the last pair of a frame is written.
// Backpressure: out_ready=0 holds the output; pairs arriving while draining are dropped and flag overflow.
// Ports: clk, rst (async active-low), bus (slave modport: PE pairs in, reordered samples out, status).
module fft_out_reorder #(
    parameter int N      = 16,
    parameter int BITREV = 1
) (
    input  logic               clk,
    input  logic               rst,
    fft_out_reorder_if.slave   bus
);
    localparam int LW = $clog2(N);
    localparam int PW = LW - 1;
    localparam logic [PW-1:0] P_LAST = PW'(N / 2 - 1);
    localparam logic [LW-1:0] R_LAST = LW'(N - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t        state_q;
    logic [PW-1:0] p_q;
    logic [LW-1:0] r_q;
    logic          out_valid_q;
    logic          in_ready_q;
    logic          frame_done_q;
    logic          overflow_q;

    logic [31:0]   mem [N];
    logic          wr_en;
    logic [LW-1:0] rd_addr_d;

    function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
        logic [LW-1:0] res;
        for (int i = 0; i < LW; i++) begin
            res[i] = v[LW-1-i];
        end
        return res;
    endfunction

    // Pairs are only stored while collecting; anything else is discarded.
    assign wr_en = bus.fft_pe_valid && (state_q == COLLECT);

    // Memory is deliberately not reset; it is only visible once a full frame is in.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{p_q, 1'b0}] <= bus.fft_a;
            mem[{p_q, 1'b1}] <= bus.fft_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= COLLECT;
            p_q          <= '0;
            r_q          <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.fft_pe_valid && (state_q == DRAIN)) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (bus.fft_pe_valid) begin
                        if (p_q == P_LAST) begin
                            p_q         <= '0;
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            p_q <= p_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // out_valid is high for the whole of DRAIN, so ready alone is acceptance
                    if (bus.out_ready) begin
                        if (r_q == R_LAST) begin
                            r_q          <= '0;
                            state_q      <= COLLECT;
                            out_valid_q  <= 1'b0;
                            in_ready_q   <= 1'b1;
                            frame_done_q <= 1'b1;
                        end else begin
                            r_q <= r_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Read address follows the registered read counter, so the presented sample
    // is stable for as long as the counter does not move (i.e. while stalled).
    assign rd_addr_d = (BITREV != 0) ? bitrev(r_q) : r_q;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_index  = r_q;
    assign bus.out_data   = out_valid_q ? mem[rd_addr_d] : 32'h0;
    assign bus.in_ready   = in_ready_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_fft_out_reorder.sv
module tb_fft_out_reorder;
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] dat;
    } exp_t;

    // one row per output bin: arrival sample, and the expected reals for each read-out mode
    typedef struct {
        logic [31:0] smp;
        logic [15:0] exp_br_real;
        logic [15:0] exp_nat_real;
    } vec_t;

    logic clk = 1'b0;
    logic rst_r = 1'b0;
    logic [31:0] a_r = '0;
    logic [31:0] b_r = '0;
    logic pv_r = 1'b0;
    logic rdy_r = 1'b1;
    int   rdy_mode = 0;
    int   cyc = 0;
    logic [3:0] rpat = 4'b1001;   // bit i = ready in phase i: 1,0,0,1

    int n_cmp = 0;
    int n_err = 0;

    exp_t q1[$];
    exp_t q0[$];

    // behavioural model of frame progress (value after the coming edge)
    logic drain_m = 1'b0;
    int   p_m = 0;
    int   r_m = 0;
    logic fd_m = 1'b0;
    logic ovf_m = 1'b0;

    int br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    vec_t tbl[16];

    fft_out_reorder_if #(.N(16)) bus1 ();
    fft_out_reorder_if #(.N(16)) bus0 ();

    assign bus1.fft_a = a_r;
    assign bus1.fft_b = b_r;
    assign bus1.fft_pe_valid = pv_r;
    assign bus1.out_ready = rdy_r;
    assign bus0.fft_a = a_r;
    assign bus0.fft_b = b_r;
    assign bus0.fft_pe_valid = pv_r;
    assign bus0.out_ready = rdy_r;

    fft_out_reorder #(.N(16), .BITREV(1)) dut1 (.clk(clk), .rst(rst_r), .bus(bus1));
    fft_out_reorder #(.N(16), .BITREV(0)) dut0 (.clk(clk), .rst(rst_r), .bus(bus0));

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // monitor/scoreboard on the falling edge
    always @(negedge clk) begin
        if (!rst_r) begin
            chk("rst_valid1", {31'b0, bus1.out_valid}, 32'h0);
            chk("rst_data1", bus1.out_data, 32'h0);
            chk("rst_index1", {28'b0, bus1.out_index}, 32'h0);
            chk("rst_fdone1", {31'b0, bus1.frame_done}, 32'h0);
            chk("rst_ovf1", {31'b0, bus1.overflow}, 32'h0);
            chk("rst_inrdy1", {31'b0, bus1.in_ready}, 32'h1);
            chk("rst_valid0", {31'b0, bus0.out_valid}, 32'h0);
            chk("rst_inrdy0", {31'b0, bus0.in_ready}, 32'h1);
            drain_m = 1'b0;
            p_m = 0;
            r_m = 0;
            fd_m = 1'b0;
            ovf_m = 1'b0;
        end else begin
            chk("valid1", {31'b0, bus1.out_valid}, {31'b0, drain_m});
            chk("valid0", {31'b0, bus0.out_valid}, {31'b0, drain_m});
            chk("in_ready1", {31'b0, bus1.in_ready}, {31'b0, ~drain_m});
            chk("frame_done1", {31'b0, bus1.frame_done}, {31'b0, fd_m});
            chk("frame_done0", {31'b0, bus0.frame_done}, {31'b0, fd_m});
            chk("overflow1", {31'b0, bus1.overflow}, {31'b0, ovf_m});
            chk("overflow0", {31'b0, bus0.overflow}, {31'b0, ovf_m});
            if (drain_m) begin
                if (q1.size() == 0 || q0.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got index %0d with no expected entry", bus1.out_index);
                end else begin
                    // presented sample must equal the head even while stalled
                    chk("index1", {28'b0, bus1.out_index}, {28'b0, q1[0].idx});
                    chk("data1", bus1.out_data, q1[0].dat);
                    chk("index0", {28'b0, bus0.out_index}, {28'b0, q0[0].idx});
                    chk("data0", bus0.out_data, q0[0].dat);
                    if (rdy_r) begin
                        q1.delete(0);
                        q0.delete(0);
                    end
                end
            end
            fd_m = 1'b0;
            if (drain_m) begin
                if (pv_r) ovf_m = 1'b1;
                if (rdy_r) begin
                    if (r_m == 15) begin
                        r_m = 0;
                        drain_m = 1'b0;
                        fd_m = 1'b1;
                    end else begin
                        r_m++;
                    end
                end
            end else if (pv_r) begin
                if (p_m == 7) begin
                    p_m = 0;
                    drain_m = 1'b1;
                end else begin
                    p_m++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rdy_r = (rdy_mode == 0) ? 1'b1 : rpat[cyc % 4];
    endtask

    task automatic push_frame(input logic [31:0] s[16]);
        for (int r = 0; r < 16; r++) begin
            q1.push_back('{idx: 4'(r), dat: s[br_tab[r]]});
            q0.push_back('{idx: 4'(r), dat: s[r]});
        end
    endtask

    task automatic send_pairs(input logic [31:0] s[16], input int npairs, input int gap);
        for (int p = 0; p < npairs; p++) begin
            a_r = s[2*p];
            b_r = s[2*p+1];
            pv_r = 1'b1;
            tick();
            pv_r = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((drain_m || q1.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", q1.size());
            q1.delete();
            q0.delete();
        end
        tick();
        tick();
    endtask

    task automatic do_reset(input int cycles);
        rst_r = 1'b0;
        q1.delete();
        q0.delete();
        for (int i = 0; i < cycles; i++) tick();
        rst_r = 1'b1;
    endtask

    initial begin
        logic [31:0] s[16];
        logic [31:0] e1[16];
        logic [31:0] e0[16];

        for (int k = 0; k < 16; k++) begin
            tbl[k].smp = {16'(k), 16'h0};
            tbl[k].exp_br_real = 16'(br_tab[k]);
            tbl[k].exp_nat_real = 16'(k);
        end

        do_reset(3);

        // table-driven frame: ramp with out_ready=1, both read-out modes
        for (int k = 0; k < 16; k++) s[k] = tbl[k].smp;
        for (int r = 0; r < 16; r++) begin
            e1[r] = {tbl[r].exp_br_real, 16'h0};
            e0[r] = {tbl[r].exp_nat_real, 16'h0};
            q1.push_back('{idx: 4'(r), dat: e1[r]});
            q0.push_back('{idx: 4'(r), dat: e0[r]});
        end
        send_pairs(s, 8, 0);
        wait_drain();

        // pairs on alternate cycles, output ready pattern 1,0,0,1
        for (int k = 0; k < 16; k++) s[k] = {16'(k + 16'h100), 16'(16'hA000 + k)};
        push_frame(s);
        rdy_mode = 1;
        send_pairs(s, 8, 1);
        wait_drain();
        rdy_mode = 0;
        rdy_r = 1'b1;

        // garbage pairs through the whole drain, including the final acceptance
        for (int k = 0; k < 16; k++) s[k] = {16'(k * 3), 16'(16'h5000 + k)};
        push_frame(s);
        send_pairs(s, 8, 0);
        a_r = {16'h7FFF, 16'h8000};
        b_r = {16'h7FFF, 16'h8000};
        pv_r = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        pv_r = 1'b0;
        wait_drain();
        for (int k = 0; k < 16; k++) s[k] = {16'(16'h2000 + k), 16'(k)};
        push_frame(s);
        send_pairs(s, 8, 0);
        wait_drain();

        // reset after 3 pairs, then mid-drain at index 5
        for (int k = 0; k < 16; k++) s[k] = {16'h0BAD, 16'(k)};
        send_pairs(s, 3, 0);
        do_reset(2);
        for (int k = 0; k < 16; k++) s[k] = {16'(16'h3000 + k), 16'hCAFE};
        push_frame(s);
        send_pairs(s, 8, 0);
        for (int i = 0; i < 5; i++) tick();
        do_reset(2);
        for (int k = 0; k < 16; k++) s[k] = {16'(16'h4000 + k), 16'(16'h1234 + k)};
        push_frame(s);
        send_pairs(s, 8, 0);
        wait_drain();

        // extreme values land bit-exact at their reordered bins
        for (int k = 0; k < 16; k++) s[k] = $urandom;
        s[1]  = {16'h8000, 16'hFFFF};
        s[6]  = {16'hFFFF, 16'h8000};
        s[11] = {16'h8000, 16'h8000};
        s[15] = {16'hFFFF, 16'hFFFF};
        push_frame(s);
        rdy_mode = 1;
        send_pairs(s, 8, 0);
        wait_drain();
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
